press_counter_bank: RTL
=======================

Name: press_counter_bank

Overview:
- Instruction-driven peripheral on the sequencer's oreg/oreg_wen bus.
- Generalises the single up/down press counter to Channels independent counters, each with its own debounced up and down button.
- Counter width is parametrised, and a wrap or saturate mode is selected at run time.
- Selected channel's count feeds a sequencer ireg; debounced button levels are exported for status polling.

Parameters:
- Channels, 4, number of independent counters (1..256)
- Width, 8, counter width in bits (1..8)
- DebounceWait, 40000, cycles a synchronised input must differ from the stable level before the level flips (>=2, < 2^DebounceSize)
- DebounceSize, 16, debounce counter width

Ports:
- clock  in  1  single clock (the peripheral phase, clock180 at top level)
- reset  in  1  asynchronous, active-high
- inst  in  12  instruction: [11:8] opcode, [7:0] immediate
- inst_en  in  1  instruction valid for one cycle
- btn_up  in  Channels  raw asynchronous up buttons, active-high
- btn_dn  in  Channels  raw asynchronous down buttons, active-high
- count  out  Width  registered count of the selected channel
- status_up  out  Channels  debounced up levels
- status_dn  out  Channels  debounced down levels

Behaviour:
- Reset (async, active-high):
  - all counts 0, count 0, status_up/status_dn 0
  - sel 0, mode wrap
  - synchronisers and debounce counters 0
  - reset mid-debounce or mid-instruction discards all in-flight state
- Per button path:
  - 2-flop synchroniser, then debounce
  - debounce counter clears whenever synced == stable, otherwise increments
  - when counter reaches DebounceWait-1 and synced still differs: stable <= synced, counter <= 0
  - a glitch shorter than DebounceWait cycles never changes stable
- Press event: stable 0->1, detected with a one-cycle delayed copy.
  - Event asserts exactly one cycle, in the cycle after the stable rise.
  - Releases produce no event.
- Count update, per channel, in the cycle the events are seen:
  - up only: +1
  - down only: -1
  - up and down together: no change
- Modes:
  - wrap (mode=0): max+1 -> 0, 0-1 -> max
  - saturate (mode=1): holds at max (2^Width-1) and at 0
- Opcodes (acted on only when inst_en=1; all others are NOP):
  - 0x0 NOP
  - 0x1 SEL: sel <= imm when imm < Channels, else ignored (sel unchanged)
  - 0x2 CLR: count[imm] <= 0 when imm < Channels, else ignored
  - 0x3 CLRALL: all counts <= 0
  - 0x4 MODE: mode <= imm[0]; imm[7:1] ignored
  - 0x5 LOAD: count[sel] <= imm[Width-1:0] (truncated)
- Simultaneous events: CLR/CLRALL/LOAD on a channel override that channel's press event in the same cycle; the press is lost. Other channels update normally.
- MODE takes effect on events one cycle later. An event in the same cycle as MODE uses the old mode.
- count <= counts[sel] every cycle, using post-update values, so it lags the internal counter by one cycle.
- SEL is visible on count one cycle after the instruction cycle.
- Latency, button edge to count: 2 (sync) + DebounceWait + 1 (edge detect) + 1 (counter) + 1 (output register) cycles.

Decomposition:
- Shared package press_counter_pkg:
  - opcode constants OP_NOP, OP_SEL, OP_CLR, OP_CLRALL, OP_MODE, OP_LOAD
  - MODE_WRAP=0, MODE_SAT=1
  - field positions OPCODE_HI=11, OPCODE_LO=8, IMM_HI=7, IMM_LO=0
- Sub-module press_debounce (params DebounceWait, DebounceSize):
  - ports clock, reset, raw, stable, press
  - instantiated 2*Channels times
- Top level contains the counters, sel/mode registers, instruction decode and output mux.

Test Plan (DebounceWait=4, Channels=4, Width=8):
- Hold btn_up[1]=1 for 20 cycles after reset -> status_up[1] rises 6 cycles after the input edge; counts[1]=1. After SEL 1, count=1 and stays 1 while held.
- Pulse btn_up[0] high for 3 cycles -> status_up[0] stays 0 and count stays 0. Then 5 clean presses on btn_dn[0] in wrap mode -> count=0xFB.
- MODE 1, LOAD 0xFE on sel 2, then 3 up presses -> count 0xFF, saturating. 300 down presses would take too long, so LOAD 0x01 and 2 down presses -> 0x00.
- btn_up[3] and btn_dn[3] released simultaneously after debounce -> count unchanged. Press event on channel 3 in the same cycle as CLR 3 -> counts[3]=0.
- SEL 7 (out of range) after SEL 2 -> sel stays 2. CLR 9 -> no counter changes.
- Assert reset mid-debounce with counts nonzero -> all outputs 0 immediately (async). After release, the held button needs a full 2+DebounceWait cycles again before its next event.

Source files
------------

// File: rtl/press_counter_pkg.sv
// Shared opcode, mode and instruction-field definitions for the press counter bank.
// Pure definitions, no timing.
package press_counter_pkg;

  localparam int OPCODE_HI = 11;
  localparam int OPCODE_LO = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_SEL    = 4'h1,
    OP_CLR    = 4'h2,
    OP_CLRALL = 4'h3,
    OP_MODE   = 4'h4,
    OP_LOAD   = 4'h5
  } opcode_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic [3:0] inst_opcode(input logic [11:0] inst);
    return inst[OPCODE_HI:OPCODE_LO];
  endfunction

  function automatic logic [7:0] inst_imm(input logic [11:0] inst);
    return inst[IMM_HI:IMM_LO];
  endfunction

endpackage

// File: rtl/press_counter_bank_if.sv
// Sequencer-side bus of the press counter bank: instruction in, selected count out.
// Single-cycle instruction strobe, no backpressure.
interface press_counter_bank_if #(
  parameter int Width = 8
);
  logic [11:0]      inst;
  logic             inst_en;
  logic [Width-1:0] count;

  modport master (output inst, output inst_en, input count);
  modport slave  (input inst, input inst_en, output count);
endinterface

// File: rtl/press_debounce.sv
// One button path: 2-flop synchroniser, debounce counter and rising-edge press pulse.
// stable follows raw 2+DebounceWait cycles later; press is a one-cycle pulse one cycle after that.
module press_debounce #(
  parameter int DebounceWait = 40000,
  parameter int DebounceSize = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam logic [DebounceSize-1:0] LastCnt = DebounceSize'(DebounceWait - 1);

  logic                    sync1;
  logic                    sync2;
  logic                    stable_d;
  logic [DebounceSize-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle where the synced level agrees with stable restarts the wait.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LastCnt) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/press_counter_bank.sv
// Bank of Channels debounced up/down press counters driven by sequencer instructions.
// Press-to-count latency 2+DebounceWait+3 cycles; instructions act in one cycle, no backpressure.
module press_counter_bank
  import press_counter_pkg::*;
#(
  parameter int Channels     = 4,
  parameter int Width        = 8,
  parameter int DebounceWait = 40000,
  parameter int DebounceSize = 16
) (
  input  logic                clock,
  input  logic                reset,
  press_counter_bank_if.slave bus,
  input  logic [Channels-1:0] btn_up,
  input  logic [Channels-1:0] btn_dn,
  output logic [Channels-1:0] status_up,
  output logic [Channels-1:0] status_dn
);

  localparam int SelW = (Channels > 1) ? $clog2(Channels) : 1;

  logic [Channels-1:0] press_up;
  logic [Channels-1:0] press_dn;

  for (genvar i = 0; i < Channels; i++) begin : g_chan
    press_debounce #(
      .DebounceWait(DebounceWait),
      .DebounceSize(DebounceSize)
    ) u_up (
      .clock (clock),
      .reset (reset),
      .raw   (btn_up[i]),
      .stable(status_up[i]),
      .press (press_up[i])
    );
    press_debounce #(
      .DebounceWait(DebounceWait),
      .DebounceSize(DebounceSize)
    ) u_dn (
      .clock (clock),
      .reset (reset),
      .raw   (btn_dn[i]),
      .stable(status_dn[i]),
      .press (press_dn[i])
    );
  end

  logic [Width-1:0] counts [Channels];
  logic [SelW-1:0]  sel;
  logic             mode;

  logic [3:0] op;
  logic [7:0] imm;
  logic       imm_ok;
  logic       do_sel, do_clr, do_clrall, do_mode, do_load;

  always_comb begin
    op        = inst_opcode(bus.inst);
    imm       = inst_imm(bus.inst);
    imm_ok    = int'(imm) < Channels;
    do_sel    = bus.inst_en && (op == OP_SEL) && imm_ok;
    do_clr    = bus.inst_en && (op == OP_CLR) && imm_ok;
    do_clrall = bus.inst_en && (op == OP_CLRALL);
    do_mode   = bus.inst_en && (op == OP_MODE);
    do_load   = bus.inst_en && (op == OP_LOAD);
  end

  function automatic logic [Width-1:0] step(input logic [Width-1:0] c, input logic up,
                                            input logic dn, input logic md);
    logic [Width-1:0] maxv;
    maxv = '1;
    if (up && !dn) return (md == MODE_SAT && c == maxv) ? c : c + 1'b1;
    if (dn && !up) return (md == MODE_SAT && c == '0) ? c : c - 1'b1;
    return c;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Channels; i++) counts[i] <= '0;
      sel       <= '0;
      mode      <= MODE_WRAP;
      bus.count <= '0;
    end else begin
      if (do_sel)  sel  <= imm[SelW-1:0];
      if (do_mode) mode <= imm[0];
      // Instruction writes win over that channel's press event; the press is dropped.
      for (int i = 0; i < Channels; i++) begin
        if (do_clrall || (do_clr && int'(imm) == i))
          counts[i] <= '0;
        else if (do_load && int'(sel) == i)
          counts[i] <= imm[Width-1:0];
        else
          counts[i] <= step(counts[i], press_up[i], press_dn[i], mode);
      end
      bus.count <= counts[sel];
    end
  end

endmodule
